// File: rtl/brent_kung_pipe_adder_if.sv
// ----------------------------------------------------------------------------
// brent_kung_pipe_adder_if
// Operand / result stream bundle for the pipelined Brent-Kung adder.
//   master : producer + consumer side (testbench or upstream logic)
//   slave  : the adder itself
// Signals:
//   a, b       operands                      (master -> slave)
//   ci         carry-in / borrow-in          (master -> slave)
//   sub        0 = add, 1 = subtract         (master -> slave)
//   tag_in     sideband tag                  (master -> slave)
//   in_valid   operands valid                (master -> slave)
//   in_ready   adder accepts operands        (slave  -> master)
//   s          {carry-out, sum}              (slave  -> master)
//   tag_out    tag of the current result     (slave  -> master)
//   out_valid  s / tag_out valid             (slave  -> master)
//   out_ready  consumer takes the result     (master -> slave)
// ----------------------------------------------------------------------------
interface brent_kung_pipe_adder_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic [TAG_W-1:0] tag_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   s;
    logic [TAG_W-1:0] tag_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, ci, sub, tag_in, in_valid, out_ready,
        input  in_ready, s, tag_out, out_valid
    );

    modport slave (
        input  a, b, ci, sub, tag_in, in_valid, out_ready,
        output in_ready, s, tag_out, out_valid
    );
endinterface

// File: rtl/brent_kung_pipe_adder.sv
// ----------------------------------------------------------------------------
// brent_kung_pipe_adder
// Parametrised Brent-Kung prefix adder/subtractor with valid/ready streaming.
//   S = (A + (SUB ? ~B : B) + (CI ^ SUB)) mod 2^(WIDTH+1), S[WIDTH] = carry-out
//   (in subtract mode S[WIDTH] = 1 means "no borrow").
// Pipeline: input register (generate/propagate), 2*log2(WIDTH)-1 prefix
// levels (each registered when PIPELINED != 0, otherwise combinational), and
// an output register. One global advance enable moves every stage together;
// bubbles are kept, not collapsed.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears every stage
//   bus  brent_kung_pipe_adder_if.slave operand/result stream
// ----------------------------------------------------------------------------
module brent_kung_pipe_adder #(
    parameter int WIDTH     = 8,
    parameter int PIPELINED = 1,
    parameter int TAG_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    brent_kung_pipe_adder_if.slave bus
);

    localparam int LOG_W  = $clog2(WIDTH);
    localparam int LEVELS = 2 * LOG_W - 1;
    localparam int GP_W   = 2 * WIDTH;
    // sideband travelling with the prefix data: {valid, tag, c0, bitwise p}
    localparam int SIDE_W = 1 + TAG_W + 1 + WIDTH;

    // One Brent-Kung level on packed {G, P}. Levels 0..LOG_W-1 are the
    // up-sweep (span doubles), the rest the down-sweep (span halves) that
    // fills in the remaining prefixes. Because c0 was folded into g_0, the
    // final G_i is the carry out of bit i.
    function automatic logic [GP_W-1:0] prefix_level(input logic [GP_W-1:0] gp, input int lv);
        logic [WIDTH-1:0] g_in;
        logic [WIDTH-1:0] p_in;
        logic [WIDTH-1:0] g_out;
        logic [WIDTH-1:0] p_out;
        logic             up;
        logic             active;
        int               k;
        int               span;
        int               j;
        g_in  = gp[GP_W-1:WIDTH];
        p_in  = gp[WIDTH-1:0];
        g_out = g_in;
        p_out = p_in;
        up    = (lv < LOG_W);
        if (up) begin
            k = lv;
        end else begin
            k = 2 * LOG_W - 2 - lv;
        end
        span = 32'sd1 <<< k;
        for (int i = 0; i < WIDTH; i++) begin
            if (up) begin
                active = (((i + 32'sd1) % (32'sd2 * span)) == 32'sd0);
            end else begin
                active = (((i + 32'sd1) % (32'sd2 * span)) == span) && ((i + 32'sd1) > (32'sd2 * span));
            end
            j = (i >= span) ? (i - span) : 32'sd0;
            if (active) begin
                g_out[i] = g_in[i] | (p_in[i] & g_in[j]);
                p_out[i] = p_in[i] & p_in[j];
            end else begin
                g_out[i] = g_in[i];
                p_out[i] = p_in[i];
            end
        end
        return {g_out, p_out};
    endfunction

    logic             ce_s;
    logic [WIDTH-1:0] be_s;
    logic [WIDTH-1:0] g0_s;
    logic [WIDTH-1:0] p0_s;
    logic             c0_s;

    logic [GP_W-1:0]   stg0_gp_r;
    logic [SIDE_W-1:0] stg0_side_r;

    logic [WIDTH-1:0]  fin_g_s;
    logic [SIDE_W-1:0] fin_side_s;

    logic [WIDTH-1:0]  po_s;
    logic              c0f_s;
    logic              vf_s;
    logic [TAG_W-1:0]  tagf_s;
    logic [WIDTH:0]    s_nxt_s;

    logic [WIDTH:0]    s_r;
    logic [TAG_W-1:0]  tag_out_r;
    logic              out_valid_r;

    // global advance: everything moves unless a held result is not taken
    assign ce_s         = ~out_valid_r | bus.out_ready;
    assign bus.in_ready = ce_s;

    // operand conditioning and per-bit generate/propagate
    always_comb begin
        be_s    = bus.sub ? ~bus.b : bus.b;
        c0_s    = bus.ci ^ bus.sub;
        p0_s    = bus.a ^ be_s;
        g0_s    = bus.a & be_s;
        g0_s[0] = g0_s[0] | (p0_s[0] & c0_s);
    end

    // stage 0 input register; valid follows in_valid so bubbles propagate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg0_gp_r   <= '0;
            stg0_side_r <= '0;
        end else if (ce_s) begin
            stg0_gp_r   <= {g0_s, p0_s};
            stg0_side_r <= {bus.in_valid, bus.tag_in, c0_s, p0_s};
        end
    end

    generate
        if (PIPELINED != 0) begin : g_pipe
            logic [GP_W-1:0]   lvl_gp_r   [0:LEVELS-1];
            logic [SIDE_W-1:0] lvl_side_r [0:LEVELS-1];

            // one register per prefix level, all advancing on the shared enable
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int lv = 0; lv < LEVELS; lv++) begin
                        lvl_gp_r[lv]   <= '0;
                        lvl_side_r[lv] <= '0;
                    end
                end else if (ce_s) begin
                    lvl_gp_r[0]   <= prefix_level(stg0_gp_r, 0);
                    lvl_side_r[0] <= stg0_side_r;
                    for (int lv = 1; lv < LEVELS; lv++) begin
                        lvl_gp_r[lv]   <= prefix_level(lvl_gp_r[lv-1], lv);
                        lvl_side_r[lv] <= lvl_side_r[lv-1];
                    end
                end
            end

            assign fin_g_s    = lvl_gp_r[LEVELS-1][GP_W-1:WIDTH];
            assign fin_side_s = lvl_side_r[LEVELS-1];
        end else begin : g_comb
            logic [GP_W-1:0] gp_v;

            // whole prefix tree as one combinational cloud after stage 0
            always_comb begin
                gp_v = stg0_gp_r;
                for (int lv = 0; lv < LEVELS; lv++) begin
                    gp_v = prefix_level(gp_v, lv);
                end
                fin_g_s = gp_v[GP_W-1:WIDTH];
            end

            assign fin_side_s = stg0_side_r;
        end
    endgenerate

    // sum bits: propagate XOR carry-into-bit (carry into bit 0 is c0)
    always_comb begin
        {vf_s, tagf_s, c0f_s, po_s} = fin_side_s;
        s_nxt_s = {fin_g_s[WIDTH-1], po_s ^ {fin_g_s[WIDTH-2:0], c0f_s}};
    end

    // output register; replaced in place when the consumer takes the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r         <= '0;
            tag_out_r   <= '0;
            out_valid_r <= 1'b0;
        end else if (ce_s) begin
            s_r         <= s_nxt_s;
            tag_out_r   <= tagf_s;
            out_valid_r <= vf_s;
        end
    end

    assign bus.s         = s_r;
    assign bus.tag_out   = tag_out_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_brent_kung_pipe_adder.sv
// ----------------------------------------------------------------------------
// tb_brent_kung_pipe_adder
// Three adder instances: WIDTH=8 pipelined, WIDTH=16 combinational prefix,
// WIDTH=32 pipelined. A per-instance scoreboard predicts each accepted
// operation with plain integer arithmetic and checks results in issue order.
// ----------------------------------------------------------------------------
module tb_brent_kung_pipe_adder;

    logic clk = 1'b0;
    logic rst8, rst16, rst32;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    brent_kung_pipe_adder_if #(.WIDTH(8),  .TAG_W(4)) b8  ();
    brent_kung_pipe_adder_if #(.WIDTH(16), .TAG_W(4)) b16 ();
    brent_kung_pipe_adder_if #(.WIDTH(32), .TAG_W(4)) b32 ();

    brent_kung_pipe_adder #(.WIDTH(8),  .PIPELINED(1), .TAG_W(4)) dut8  (.clk(clk), .rst(rst8),  .bus(b8));
    brent_kung_pipe_adder #(.WIDTH(16), .PIPELINED(0), .TAG_W(4)) dut16 (.clk(clk), .rst(rst16), .bus(b16));
    brent_kung_pipe_adder #(.WIDTH(32), .PIPELINED(1), .TAG_W(4)) dut32 (.clk(clk), .rst(rst32), .bus(b32));

    logic [64:0] qs8[$],  qs16[$],  qs32[$];
    logic [3:0]  qt8[$],  qt16[$],  qt32[$];
    int          pop8 = 0;

    task automatic check_val(input string name, input logic [65:0] got, input logic [65:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // reference: add is A+B+CI; subtract is A-B-CI offset by 2^w (no-borrow flag)
    function automatic logic [64:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic sub);
        logic [65:0] r;
        logic [65:0] m;
        m = (66'd1 << (w + 1)) - 66'd1;
        if (sub) r = {2'b00, a} - {2'b00, b} - {65'd0, ci} + (66'd1 << w);
        else     r = {2'b00, a} + {2'b00, b} + {65'd0, ci};
        r = r & m;
        return r[64:0];
    endfunction

    // scoreboards: predict on accept, compare on consume (sampled at negedge)
    always @(negedge clk) begin
        if (!rst8) begin
            if (b8.out_valid && b8.out_ready) begin
                pop8++;
                check_val("w8 outq nonempty", 66'(qs8.size() != 0), 66'd1);
                if (qs8.size() != 0) begin
                    check_val("w8 s",   66'(b8.s),       66'(qs8.pop_front()));
                    check_val("w8 tag", 66'(b8.tag_out), 66'(qt8.pop_front()));
                end
            end
            if (b8.in_valid && b8.in_ready) begin
                qs8.push_back(model(8, 64'(b8.a), 64'(b8.b), b8.ci, b8.sub));
                qt8.push_back(b8.tag_in);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst16) begin
            if (b16.out_valid && b16.out_ready) begin
                check_val("w16 outq nonempty", 66'(qs16.size() != 0), 66'd1);
                if (qs16.size() != 0) begin
                    check_val("w16 s",   66'(b16.s),       66'(qs16.pop_front()));
                    check_val("w16 tag", 66'(b16.tag_out), 66'(qt16.pop_front()));
                end
            end
            if (b16.in_valid && b16.in_ready) begin
                qs16.push_back(model(16, 64'(b16.a), 64'(b16.b), b16.ci, b16.sub));
                qt16.push_back(b16.tag_in);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst32) begin
            if (b32.out_valid && b32.out_ready) begin
                check_val("w32 outq nonempty", 66'(qs32.size() != 0), 66'd1);
                if (qs32.size() != 0) begin
                    check_val("w32 s",   66'(b32.s),       66'(qs32.pop_front()));
                    check_val("w32 tag", 66'(b32.tag_out), 66'(qt32.pop_front()));
                end
            end
            if (b32.in_valid && b32.in_ready) begin
                qs32.push_back(model(32, 64'(b32.a), 64'(b32.b), b32.ci, b32.sub));
                qt32.push_back(b32.tag_in);
            end
        end
    end

    // a reset discards everything in flight
    always @(posedge rst8) begin
        qs8.delete();
        qt8.delete();
    end

    function automatic logic get_ov(input int id);
        case (id)
            8:       return b8.out_valid;
            16:      return b16.out_valid;
            default: return b32.out_valid;
        endcase
    endfunction

    function automatic logic [64:0] get_s(input int id);
        case (id)
            8:       return 65'(b8.s);
            16:      return 65'(b16.s);
            default: return 65'(b32.s);
        endcase
    endfunction

    function automatic int qsize(input int id);
        case (id)
            8:       return qs8.size();
            16:      return qs16.size();
            default: return qs32.size();
        endcase
    endfunction

    task automatic drv(input int id, input logic [63:0] a, input logic [63:0] b, input logic ci,
                       input logic sub, input logic [3:0] tag, input logic v);
        case (id)
            8: begin
                b8.a = a[7:0]; b8.b = b[7:0]; b8.ci = ci; b8.sub = sub; b8.tag_in = tag; b8.in_valid = v;
            end
            16: begin
                b16.a = a[15:0]; b16.b = b[15:0]; b16.ci = ci; b16.sub = sub; b16.tag_in = tag; b16.in_valid = v;
            end
            default: begin
                b32.a = a[31:0]; b32.b = b[31:0]; b32.ci = ci; b32.sub = sub; b32.tag_in = tag; b32.in_valid = v;
            end
        endcase
    endtask

    // one operation into an idle pipe; latency counts the accepting edge as 1
    task automatic single(input int id, input logic [63:0] a, input logic [63:0] b, input logic ci,
                          input logic sub, input int exp_lat, input logic [64:0] exp_s, input string nm);
        int n;
        drv(id, a, b, ci, sub, 4'h5, 1'b1);
        @(posedge clk); #1;
        n = 1;
        drv(id, 64'd0, 64'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        while (!get_ov(id) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({nm, " lat"}, 66'(n), 66'(exp_lat));
        check_val({nm, " s"}, 66'(get_s(id)), 66'(exp_s));
    endtask

    task automatic drain(input int id, input string nm);
        int n;
        n = 0;
        while (qsize(id) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({nm, " drained"}, 66'(qsize(id)), 66'd0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int          edges;
        int          p0;
        int          stalls;
        int          stale;
        int          n_sent;
        logic        seen;
        logic        prev_v;
        logic        v;
        logic        snap_ov, snap_ordy, snap_rdy;
        logic [8:0]  snap_s;
        logic [3:0]  snap_tag;
        logic [15:0] pair;

        rst8 = 1'b1; rst16 = 1'b1; rst32 = 1'b1;
        drv(8,  64'd0, 64'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        drv(16, 64'd0, 64'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        drv(32, 64'd0, 64'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        b8.out_ready = 1'b1; b16.out_ready = 1'b1; b32.out_ready = 1'b1;
        #1;
        check_val("reset out_valid", 66'(b8.out_valid), 66'd0);
        check_val("reset s",         66'(b8.s),         66'd0);
        check_val("reset tag",       66'(b8.tag_out),   66'd0);
        check_val("reset in_ready",  66'(b8.in_ready),  66'd1);
        check_val("reset w32 ov",    66'(b32.out_valid), 66'd0);
        #11;
        rst8 = 1'b0; rst16 = 1'b0; rst32 = 1'b0;
        @(posedge clk); #1;

        // directed add/subtract corner cases
        single(8, 64'd5,   64'd7,   1'b0, 1'b1, 7, 65'h0FE, "sub 5-7");
        single(8, 64'd7,   64'd5,   1'b0, 1'b1, 7, 65'h102, "sub 7-5");
        single(8, 64'd7,   64'd5,   1'b1, 1'b1, 7, 65'h101, "sub 7-5-1");
        single(8, 64'd255, 64'd255, 1'b1, 1'b0, 7, 65'h1FF, "add ff+ff+1");
        drain(8, "w8 directed");

        // exhaustive back-to-back A+B
        p0 = pop8; seen = 1'b0; edges = 0;
        for (int i = 0; i < 65536; i++) begin
            pair = i[15:0];
            drv(8, 64'(pair[15:8]), 64'(pair[7:0]), 1'b0, 1'b0, pair[3:0], 1'b1);
            @(posedge clk); #1;
            edges++;
            if (!seen && b8.out_valid) begin
                seen = 1'b1;
                check_val("w8 first lat", 66'(edges), 66'd7);
            end
        end
        drv(8, 64'd0, 64'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        drain(8, "w8 exhaustive");
        check_val("w8 exhaustive count", 66'(pop8 - p0), 66'd65536);

        // backpressure: 20 tagged ops, consumer stalls for 5 cycles mid-stream
        p0 = pop8; n_sent = 0; stalls = 0;
        for (int cyc = 0; cyc < 200 && n_sent < 20; cyc++) begin
            b8.out_ready = !(cyc >= 10 && cyc < 15);
            if (!b8.in_valid) begin
                drv(8, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'(n_sent), 1'b1);
            end
            #1;
            snap_ov = b8.out_valid; snap_ordy = b8.out_ready; snap_rdy = b8.in_ready;
            snap_s = b8.s; snap_tag = b8.tag_out;
            @(posedge clk); #1;
            if (snap_ov && !snap_ordy) begin
                stalls++;
                check_val("bp in_ready", 66'(snap_rdy), 66'd0);
                check_val("bp hold s",   66'(b8.s),       66'(snap_s));
                check_val("bp hold tag", 66'(b8.tag_out), 66'(snap_tag));
                check_val("bp hold ov",  66'(b8.out_valid), 66'd1);
            end
            if (snap_rdy) begin
                n_sent++;
                b8.in_valid = 1'b0;
            end
        end
        drv(8, 64'd0, 64'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        b8.out_ready = 1'b1;
        drain(8, "bp");
        check_val("bp stall cycles", 66'(stalls), 66'd5);
        check_val("bp count", 66'(pop8 - p0), 66'd20);

        // asynchronous reset with operations in flight
        for (int i = 0; i < 9; i++) begin
            drv(8, 64'd200, 64'd100, 1'b0, 1'b0, 4'(i), 1'b1);
            @(posedge clk); #1;
        end
        drv(8, 64'd0, 64'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        check_val("rst pre ov", 66'(b8.out_valid), 66'd1);
        #2;
        rst8 = 1'b1;
        #1;
        check_val("rst ov",       66'(b8.out_valid), 66'd0);
        check_val("rst s",        66'(b8.s),         66'd0);
        check_val("rst tag",      66'(b8.tag_out),   66'd0);
        check_val("rst in_ready", 66'(b8.in_ready),  66'd1);
        @(posedge clk); @(posedge clk); #3;
        rst8 = 1'b0;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (b8.out_valid) stale++;
        end
        check_val("rst no stale", 66'(stale), 66'd0);
        single(8, 64'd17, 64'd34, 1'b1, 1'b0, 7, 65'h034, "post-rst");
        drain(8, "w8 post-rst");

        // WIDTH=16, combinational prefix: full carry ripple and bubbles
        single(16, 64'hFFFF, 64'd1, 1'b0, 1'b0, 2, 65'h10000, "w16 ffff+1");
        prev_v = 1'b0;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 99) < 30);
            drv(16, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom), v);
            @(posedge clk); #1;
            check_val("w16 bubble", 66'(b16.out_valid), 66'(prev_v));
            prev_v = v;
        end
        drv(16, 64'd0, 64'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        drain(16, "w16");

        // WIDTH=32 pipelined: latency, then random traffic and backpressure
        single(32, 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0, 11, 65'h1_0000_0000, "w32 carry");
        for (int i = 0; i < 4000; i++) begin
            drv(32, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom), ($urandom_range(0, 99) < 85));
            b32.out_ready = ($urandom_range(0, 99) < 70);
            @(posedge clk); #1;
        end
        drv(32, 64'd0, 64'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        b32.out_ready = 1'b1;
        drain(32, "w32");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
